// File: rtl/fft_sched_pkg.sv
// Shared state encoding and default sizing for the FFT frame sequencer.
package fft_sched_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, REPORT} state_t;

  localparam int DEF_LOG2N         = 14;
  localparam int DEF_DATA_W        = 48;
  localparam int DEF_MAG_W         = 16;
  localparam int DEF_DRAIN_TIMEOUT = 65535;
endpackage

// File: rtl/fft_peak_track.sv
// Running peak over positive-frequency bins; strict-greater compare keeps the earliest (lowest) bin on ties.
module fft_peak_track
  import fft_sched_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int MAG_W = DEF_MAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [MAG_W-1:0] mag,
  input  logic [15:0]      addr,
  output logic [MAG_W-1:0] nxt_mag,
  output logic [15:0]      nxt_bin
);
  logic [MAG_W-1:0] run_mag;
  logic [15:0]      run_bin;
  logic             bin_ok;

  // Bins 1..N/2-1: nonzero and top index bit clear.
  assign bin_ok = (addr[LOG2N-1:0] != '0) && !addr[LOG2N-1];

  always_comb begin
    nxt_mag = run_mag;
    nxt_bin = run_bin;
    if (upd && bin_ok && (mag > run_mag)) begin
      nxt_mag = mag;
      nxt_bin = addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mag <= '0;
      run_bin <= 16'd1;
    end else if (clr) begin
      run_mag <= '0;
      run_bin <= 16'd1;
    end else begin
      run_mag <= nxt_mag;
      run_bin <= nxt_bin;
    end
  end
endmodule

// File: rtl/fft_frame_sched.sv
// Gates the sample stream into N-sample FFT frames, drains N magnitudes, and reports the peak bin.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int LOG2N         = DEF_LOG2N,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAG_W         = DEF_MAG_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_sample_data,
  input  logic              s_sample_valid,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_valid,
  output logic              fft_tlast,
  input  logic              fft_tready,
  input  logic              mag_valid,
  input  logic [MAG_W-1:0]  mag_data,
  input  logic [15:0]       mag_addr,
  output logic              busy,
  output logic              frame_done,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [15:0]       peak_bin,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              timeout_err
);
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [LOG2N-1:0] LAST = '1;
  localparam logic [IW-1:0]    IDLE_LIM = IW'(DRAIN_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] acc_cnt, res_cnt;
  logic [IW-1:0]    idle_cnt;
  logic             cont_q;
  logic             in_feed, accept, drop, mag_in, last_mag, tmo, enter_feed, go;
  logic [MAG_W-1:0] nxt_mag;
  logic [15:0]      nxt_bin;

  // Abort gates the stream in the same cycle so the FFT never sees a post-abort beat.
  assign in_feed   = (state == FEED) && !abort;
  assign fft_valid = in_feed && s_sample_valid;
  assign fft_data  = in_feed ? s_sample_data : '0;
  assign fft_tlast = in_feed && (acc_cnt == LAST);
  assign accept    = fft_valid && fft_tready;
  assign drop      = fft_valid && !fft_tready;

  assign mag_in   = (state == DRAIN) && !abort && mag_valid;
  assign last_mag = mag_in && (res_cnt == LAST);
  assign tmo      = (state == DRAIN) && !abort && !mag_valid && (idle_cnt == IDLE_LIM);
  assign go       = (state == IDLE) && start && !abort;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = FEED;
        FEED:    if (accept && (acc_cnt == LAST)) state_nxt = DRAIN;
        DRAIN: begin
          if (last_mag) state_nxt = REPORT;
          else if (tmo) state_nxt = IDLE;
        end
        REPORT:  state_nxt = cont_q ? FEED : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign enter_feed = (state != FEED) && (state_nxt == FEED);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      acc_cnt     <= '0;
      res_cnt     <= '0;
      idle_cnt    <= '0;
      cont_q      <= 1'b0;
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
      peak_mag    <= '0;
      peak_bin    <= '0;
      frame_cnt   <= '0;
    end else begin
      if (enter_feed)  acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 1'b1;

      if (enter_feed)  res_cnt <= '0;
      else if (mag_in) res_cnt <= res_cnt + 1'b1;

      if ((state != DRAIN) || mag_in) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + 1'b1;

      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;

      if (go) begin
        cont_q      <= continuous;
        timeout_err <= 1'b0;
      end else if (tmo) begin
        timeout_err <= 1'b1;
      end

      // Report registers in the same edge that takes the Nth result, including that result.
      frame_done <= last_mag;
      if (last_mag) begin
        peak_mag  <= nxt_mag;
        peak_bin  <= nxt_bin;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  fft_peak_track #(.LOG2N(LOG2N), .MAG_W(MAG_W)) u_peak (
    .clk     (sys_clk),
    .rst_n   (sys_rstn),
    .clr     (enter_feed),
    .upd     (mag_in),
    .mag     (mag_data),
    .addr    (mag_addr),
    .nxt_mag (nxt_mag),
    .nxt_bin (nxt_bin)
  );
endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboarded bench for fft_frame_sched at N=16 with a short drain timeout.
module tb_fft_frame_sched;
  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int DW    = 48;
  localparam int MW    = 16;
  localparam int TMO   = 20;

  typedef struct {
    logic [15:0] mag;
    logic [15:0] bin;
    logic [15:0] fc;
    int          cyc;
  } rep_t;

  logic          sys_clk = 1'b0;
  logic          sys_rstn;
  logic          start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [DW-1:0] s_sample_data = '0;
  logic          s_sample_valid = 1'b0;
  logic [DW-1:0] fft_data;
  logic          fft_valid, fft_tlast;
  logic          fft_tready = 1'b1;
  logic          mag_valid = 1'b0;
  logic [MW-1:0] mag_data = '0;
  logic [15:0]   mag_addr = '0;
  logic          busy, frame_done, timeout_err;
  logic [MW-1:0] peak_mag;
  logic [15:0]   peak_bin, frame_cnt, drop_cnt;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          exp_drop = 0;
  logic [15:0] exp_frames = '0;
  logic [15:0] mags [N];
  rep_t        sb [$];
  rep_t        r;

  fft_frame_sched #(.LOG2N(LOG2N), .DATA_W(DW), .MAG_W(MW), .DRAIN_TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .start(start), .continuous(continuous),
    .abort(abort), .s_sample_data(s_sample_data), .s_sample_valid(s_sample_valid),
    .fft_data(fft_data), .fft_valid(fft_valid), .fft_tlast(fft_tlast), .fft_tready(fft_tready),
    .mag_valid(mag_valid), .mag_data(mag_data), .mag_addr(mag_addr), .busy(busy),
    .frame_done(frame_done), .peak_mag(peak_mag), .peak_bin(peak_bin),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every frame_done must match the oldest expected report, at the expected cycle.
  always @(negedge sys_clk) begin
    if (sys_rstn === 1'b1 && frame_done === 1'b1) begin
      if (sb.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else begin
        r = sb.pop_front();
        chk("peak_mag", 64'(peak_mag), 64'(r.mag));
        chk("peak_bin", 64'(peak_bin), 64'(r.bin));
        chk("frame_cnt", 64'(frame_cnt), 64'(r.fc));
        chk("done_latency", 64'(cyc), 64'(r.cyc));
      end
    end
  end

  task automatic do_start(input logic c);
    @(negedge sys_clk); start = 1'b1; continuous = c;
    @(negedge sys_clk); start = 1'b0; continuous = 1'b0;
    #1;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("tmo_clear_on_start", 64'(timeout_err), 64'd0);
  endtask

  // Full frame; ndrop cycles of tready low at sample 5; optional stale mag_valid during FEED.
  task automatic feed_frame(input int ndrop, input logic stale);
    int acc = 0;
    int dl = ndrop;
    logic [DW-1:0] d;
    while (acc < N) begin
      @(negedge sys_clk);
      d = DW'({$urandom(), $urandom()});
      s_sample_data = d; s_sample_valid = 1'b1;
      fft_tready = !(acc == 5 && dl > 0);
      mag_valid = stale; mag_addr = 16'd2; mag_data = 16'hFFFF;
      #1;
      chk("fft_valid", 64'(fft_valid), 64'd1);
      chk("fft_data", 64'(fft_data), 64'(d));
      chk("fft_tlast", 64'(fft_tlast), 64'(acc == N - 1));
      if (fft_tready) acc++;
      else begin dl--; exp_drop++; end
    end
    @(negedge sys_clk);
    mag_valid = 1'b0; s_sample_valid = 1'b1; fft_tready = 1'b0;
    #1 chk("drain_no_valid", 64'(fft_valid), 64'd0);
    @(negedge sys_clk);
    s_sample_valid = 1'b0; fft_tready = 1'b1;
    #1 chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic send_mags(input int cnt);
    logic [15:0] bm = 16'd0;
    logic [15:0] bb = 16'd1;
    rep_t e;
    for (int i = 0; i < cnt; i++) begin
      @(negedge sys_clk);
      mag_valid = 1'b1; mag_addr = 16'(i); mag_data = mags[i];
      if (i >= 1 && i <= N / 2 - 1 && mags[i] > bm) begin bm = mags[i]; bb = 16'(i); end
      if (i == N - 1) begin
        exp_frames++;
        e.mag = bm; e.bin = bb; e.fc = exp_frames; e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge sys_clk); mag_valid = 1'b0;
  endtask

  int t_last, n;

  initial begin
    sys_rstn = 1'b1;
    #2 sys_rstn = 1'b0;
    #1;
    chk("rst_fft_valid", 64'(fft_valid), 64'd0);
    chk("rst_fft_data", 64'(fft_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_peak", 64'({peak_mag, peak_bin}), 64'd0);
    chk("rst_counts", 64'({frame_cnt, drop_cnt}), 64'd0);
    chk("rst_flags", 64'({frame_done, timeout_err, fft_tlast}), 64'd0);
    @(negedge sys_clk); sys_rstn = 1'b1;

    // Single frame, bin 5 peak, stale magnitude during FEED ignored.
    do_start(1'b0);
    feed_frame(0, 1'b1);
    for (int i = 0; i < N; i++) mags[i] = 16'(i * 10);
    mags[5] = 16'd300;
    send_mags(N);
    @(negedge sys_clk); #1 chk("idle_after_report", 64'(busy), 64'd0);

    // DC/negative bins excluded, tie keeps lower bin.
    do_start(1'b0);
    feed_frame(0, 1'b0);
    for (int i = 0; i < N; i++) mags[i] = 16'd100;
    mags[0] = 16'hFFFF; mags[12] = 16'hFFFF; mags[3] = 16'd200; mags[6] = 16'd200;
    send_mags(N);
    @(negedge sys_clk);

    // Three drops mid-frame.
    do_start(1'b0);
    feed_frame(3, 1'b0);
    for (int i = 0; i < N; i++) mags[i] = 16'(N - i);
    send_mags(N);
    @(negedge sys_clk);

    // Continuous: FEED re-entered right after REPORT, peak recomputed.
    do_start(1'b1);
    feed_frame(0, 1'b0);
    for (int i = 0; i < N; i++) mags[i] = 16'(i * 7);
    send_mags(N);
    feed_frame(0, 1'b0);
    for (int i = 0; i < N; i++) mags[i] = 16'd50;
    mags[2] = 16'd60;
    send_mags(N);
    @(negedge sys_clk); abort = 1'b1; s_sample_valid = 1'b1;
    #1 chk("abort_gates_valid", 64'(fft_valid), 64'd0);
    @(negedge sys_clk); abort = 1'b0; s_sample_valid = 1'b0;
    #1 chk("abort_idle", 64'(busy), 64'd0);

    // Drain timeout with only 10 results.
    do_start(1'b0);
    feed_frame(0, 1'b0);
    send_mags(10);
    t_last = cyc - 1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    chk("tmo_set", 64'(timeout_err), 64'd1);
    chk("tmo_latency", 64'(cyc - t_last), 64'd21);
    chk("tmo_idle", 64'(busy), 64'd0);
    chk("tmo_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // Abort at sample 7.
    do_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk); s_sample_valid = 1'b1; fft_tready = 1'b1;
    end
    @(negedge sys_clk); abort = 1'b1;
    #1 chk("abort_feed_valid", 64'(fft_valid), 64'd0);
    @(negedge sys_clk); abort = 1'b0;
    #1;
    chk("abort_feed_idle", 64'(busy), 64'd0);
    chk("abort_feed_valid2", 64'(fft_valid), 64'd0);
    s_sample_valid = 1'b0;

    // Async reset mid-DRAIN.
    do_start(1'b0);
    feed_frame(0, 1'b0);
    send_mags(5);
    @(negedge sys_clk); #2 sys_rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_peak", 64'({peak_mag, peak_bin}), 64'd0);
    chk("mid_rst_counts", 64'({frame_cnt, drop_cnt}), 64'd0);
    chk("mid_rst_flags", 64'({frame_done, timeout_err, fft_valid}), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
